// File: rtl/slot_spi_pkg.sv
// Shared constants, opcode/state encodings and the status-word builder for the
// SPI game-state link.
package slot_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CREDIT_W   = 12;
    localparam int REEL_W     = 4;
    localparam int BITCNT_W   = 5;

    localparam logic [BITCNT_W-1:0] BITCNT_MAX = '1;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_REELS = 4'h1,
        OP_SPIN  = 4'h2,
        OP_WIN   = 4'h3,
        OP_TOTAL = 4'h4
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Word returned to the host on sdo, MSB first.
    function automatic logic [FRAME_BITS-1:0] status_word(
        input logic                busy,
        input logic                win_valid,
        input logic                total_valid,
        input logic [CREDIT_W-1:0] total
    );
        return {busy, win_valid, total_valid, 1'b0, total};
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pad with registered rise/fall
// pulses derived from the synchronized level.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_game_link.sv
// SPI slave that decodes 16-bit game-state frames from the host into registered
// reel/spin/credit controls and returns a status word on sdo.
module spi_game_link
    import slot_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                copi,
    input  logic                cs,
    output logic                sdo,
    input  logic                done,
    output logic [REEL_W-1:0]   reel1_idx,
    output logic [REEL_W-1:0]   reel2_idx,
    output logic [REEL_W-1:0]   reel3_idx,
    output logic                start_spin,
    output logic [CREDIT_W-1:0] win_credits,
    output logic                is_win,
    output logic [CREDIT_W-1:0] total_credits,
    output logic                is_total,
    output logic                spin_busy,
    output logic                frame_err
);

    localparam int PAD_SCLK = 0;
    localparam int PAD_COPI = 1;
    localparam int PAD_CS   = 2;

    logic [2:0] pad_vec;
    logic [2:0] pad_lvl;
    logic [2:0] pad_rise;
    logic [2:0] pad_fall;

    assign pad_vec = {cs, copi, sclk};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        sync_edge_detect #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (pad_vec[gi]),
            .level (pad_lvl[gi]),
            .rise  (pad_rise[gi]),
            .fall  (pad_fall[gi])
        );
    end

    logic sclk_rise, sclk_fall, copi_lvl, cs_rise, cs_fall;
    assign sclk_rise = pad_rise[PAD_SCLK];
    assign sclk_fall = pad_fall[PAD_SCLK];
    assign copi_lvl  = pad_lvl[PAD_COPI];
    assign cs_rise   = pad_rise[PAD_CS];
    assign cs_fall   = pad_fall[PAD_CS];

    logic unused_sync;
    assign unused_sync = ^{pad_lvl[PAD_SCLK], pad_lvl[PAD_CS],
                           pad_rise[PAD_COPI], pad_fall[PAD_COPI]};

    state_e                        state_q, state_d;
    logic [BITCNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]         rx_q, rx_d;
    logic [FRAME_BITS-1:0]         tx_q, tx_d;
    logic                          pend_q, pend_d;
    logic                          sdo_q, sdo_d;
    logic [2:0][REEL_W-1:0]        reel_q, reel_d;
    logic [CREDIT_W-1:0]           win_q, win_d;
    logic                          is_win_q, is_win_d;
    logic [CREDIT_W-1:0]           total_q, total_d;
    logic                          is_total_q, is_total_d;
    logic                          busy_q, busy_d;
    logic                          start_q, start_d;
    logic                          ferr_q, ferr_d;

    opcode_e                       op;
    logic [CREDIT_W-1:0]           payload;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        pend_d     = pend_q;
        reel_d     = reel_q;
        win_d      = win_q;
        is_win_d   = is_win_q;
        total_d    = total_q;
        is_total_d = is_total_q;
        busy_d     = busy_q;
        start_d    = 1'b0;
        ferr_d     = 1'b0;
        op         = opcode_e'(rx_q[FRAME_BITS-1 -: 4]);
        payload    = rx_q[CREDIT_W-1:0];

        // A spin command committing in the same cycle overrides this below.
        if (done) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall || pend_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    pend_d    = 1'b0;
                    tx_d      = status_word(busy_q, is_win_q, is_total_q, total_q);
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], copi_lvl};
                    if (bit_cnt_q != BITCNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                if (sclk_fall) begin
                    tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
                if (cs_rise) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                pend_d  = cs_fall;
                if (bit_cnt_q != BITCNT_W'(FRAME_BITS)) begin
                    ferr_d = 1'b1;
                end else begin
                    case (op)
                        OP_NOP: ;
                        OP_REELS: begin
                            if (busy_q) begin
                                ferr_d = 1'b1;
                            end else begin
                                reel_d[0] = payload[11:8];
                                reel_d[1] = payload[7:4];
                                reel_d[2] = payload[3:0];
                            end
                        end
                        OP_SPIN: begin
                            if (busy_q) begin
                                ferr_d = 1'b1;
                            end else begin
                                start_d  = 1'b1;
                                busy_d   = 1'b1;
                                is_win_d = 1'b0;
                            end
                        end
                        OP_WIN: begin
                            win_d    = payload;
                            is_win_d = 1'b1;
                        end
                        OP_TOTAL: begin
                            total_d    = payload;
                            is_total_d = 1'b1;
                        end
                        default: ferr_d = 1'b1;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        sdo_d = (state_d == SHIFT) ? tx_d[FRAME_BITS-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            pend_q     <= 1'b0;
            sdo_q      <= 1'b0;
            reel_q     <= '0;
            win_q      <= '0;
            is_win_q   <= 1'b0;
            total_q    <= '0;
            is_total_q <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            pend_q     <= pend_d;
            sdo_q      <= sdo_d;
            reel_q     <= reel_d;
            win_q      <= win_d;
            is_win_q   <= is_win_d;
            total_q    <= total_d;
            is_total_q <= is_total_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            ferr_q     <= ferr_d;
        end
    end

    assign sdo           = sdo_q;
    assign reel1_idx     = reel_q[0];
    assign reel2_idx     = reel_q[1];
    assign reel3_idx     = reel_q[2];
    assign start_spin    = start_q;
    assign win_credits   = win_q;
    assign is_win        = is_win_q;
    assign total_credits = total_q;
    assign is_total      = is_total_q;
    assign spin_busy     = busy_q;
    assign frame_err     = ferr_q;

endmodule

// File: tb/tb_spi_game_link.sv
// Randomized bench for spi_game_link: a frame-level model predicts every output
// each cycle; directed frames pin the model with literal expectations.
module tb_spi_game_link;

    localparam int SYNC = 2;
    localparam int H    = 4;   // sclk half period in clk cycles (sclk = clk/8)

    logic        clk = 1'b0;
    logic        reset, sclk, copi, cs, done;
    logic        sdo, start_spin, is_win, is_total, spin_busy, frame_err;
    logic [3:0]  reel1_idx, reel2_idx, reel3_idx;
    logic [11:0] win_credits, total_credits;

    spi_game_link #(.SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .reset         (reset),
        .sclk          (sclk),
        .copi          (copi),
        .cs            (cs),
        .sdo           (sdo),
        .done          (done),
        .reel1_idx     (reel1_idx),
        .reel2_idx     (reel2_idx),
        .reel3_idx     (reel3_idx),
        .start_spin    (start_spin),
        .win_credits   (win_credits),
        .is_win        (is_win),
        .total_credits (total_credits),
        .is_total      (is_total),
        .spin_busy     (spin_busy),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    // Frame-level reference state
    logic [3:0]  m_r1, m_r2, m_r3;
    logic [11:0] m_win, m_total;
    logic        m_is_win, m_is_total, m_busy, m_start, m_ferr;

    int          checks = 0;
    int          errors = 0;
    int          ferr_seen = 0;
    int          start_seen = 0;
    bit          chk_en = 1'b0;
    logic [15:0] exp_word;
    logic [47:0] sdo_got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r1 = 0; m_r2 = 0; m_r3 = 0;
        m_win = 0; m_total = 0;
        m_is_win = 0; m_is_total = 0; m_busy = 0; m_start = 0; m_ferr = 0;
    endtask

    // Effect of one completed frame, applied on the clock edge where it commits.
    task automatic apply_commit(input logic [15:0] f, input int nbits, input bit done_now);
        logic was_busy;
        was_busy = m_busy;
        if (done_now) m_busy = 0;
        if (nbits != 16) begin
            m_ferr = 1;
        end else begin
            case (f[15:12])
                4'h0: ;
                4'h1: if (was_busy) m_ferr = 1;
                      else begin m_r1 = f[11:8]; m_r2 = f[7:4]; m_r3 = f[3:0]; end
                4'h2: if (was_busy) m_ferr = 1;
                      else begin m_start = 1; m_busy = 1; m_is_win = 0; end
                4'h3: begin m_win = f[11:0]; m_is_win = 1; end
                4'h4: begin m_total = f[11:0]; m_is_total = 1; end
                default: m_ferr = 1;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("reel1", reel1_idx, m_r1);
            check("reel2", reel2_idx, m_r2);
            check("reel3", reel3_idx, m_r3);
            check("start_spin", start_spin, m_start);
            check("frame_err", frame_err, m_ferr);
            check("win_credits", win_credits, m_win);
            check("is_win", is_win, m_is_win);
            check("total_credits", total_credits, m_total);
            check("is_total", is_total, m_is_total);
            check("spin_busy", spin_busy, m_busy);
        end
        if (frame_err === 1'b1) ferr_seen++;
        if (start_spin === 1'b1) start_seen++;
    end

    task automatic frame_begin();
        exp_word = {m_busy, m_is_win, m_is_total, 1'b0, m_total};
        sdo_got  = '0;
        @(negedge clk);
        cs = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [47:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            copi = bits[nbits-1-i];
            repeat (H) @(negedge clk);
            sdo_got = {sdo_got[46:0], sdo};
            check("sdo_bit", sdo, (i < 16) ? exp_word[15-i] : 1'b0);
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_end(input logic [47:0] bits, input int nbits, input bit done_now);
        repeat (H) @(negedge clk);
        cs = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        if (done_now) begin
            @(negedge clk);
            done = 1'b1;
        end
        @(posedge clk);
        apply_commit(bits[15:0], nbits, done_now);
        if (done_now) begin
            @(negedge clk);
            done = 1'b0;
        end
        @(posedge clk);
        m_start = 0;
        m_ferr  = 0;
        repeat (SYNC + 3) @(negedge clk);
        check("sdo_idle", sdo, 1'b0);
    endtask

    task automatic send(input logic [47:0] bits, input int nbits, input bit done_now);
        frame_begin();
        shift_bits(bits, nbits);
        frame_end(bits, nbits, done_now);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        m_busy = 0;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          fe0;
        int          st0;
        logic [47:0] bits;
        int          nbits;
        logic [3:0]  opc;
        int          r;

        reset = 1'b1; sclk = 1'b0; copi = 1'b0; cs = 1'b1; done = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_reel1", reel1_idx, 0);
        check("rst_total", total_credits, 0);
        check("rst_busy", spin_busy, 0);
        check("rst_sdo", sdo, 0);
        repeat (8) @(negedge clk);

        send(48'h1201, 16, 0);
        check("lit_1201_r1", reel1_idx, 4'd2);
        check("lit_1201_r2", reel2_idx, 4'd0);
        check("lit_1201_r3", reel3_idx, 4'd1);

        st0 = start_seen;
        send(48'h2000, 16, 0);
        check("lit_spin_pulses", start_seen - st0, 1);
        check("lit_spin_busy", spin_busy, 1);

        fe0 = ferr_seen;
        send(48'h1333, 16, 0);
        check("lit_busy_reject", ferr_seen - fe0, 1);
        check("lit_busy_r1", reel1_idx, 4'd2);
        pulse_done();
        send(48'h1333, 16, 0);
        check("lit_1333_r1", reel1_idx, 4'd3);
        check("lit_1333_r3", reel3_idx, 4'd3);

        send(48'h3064, 16, 0);
        check("lit_win", win_credits, 12'd100);
        check("lit_is_win", is_win, 1);
        send(48'h2000, 16, 0);
        check("lit_win_clr", is_win, 0);
        check("lit_win_keep", win_credits, 12'd100);
        pulse_done();

        fe0 = ferr_seen;
        send(48'h1ab, 9, 0);
        send(48'h1abcd, 17, 0);
        send(48'h123456789abc, 48, 0);
        send(48'hF123, 16, 0);
        check("lit_bad_frames", ferr_seen - fe0, 4);
        check("lit_bad_r1", reel1_idx, 4'd3);

        send(48'h4ABC, 16, 0);
        send(48'h0000, 16, 0);
        check("lit_sdo_word", sdo_got[15:0], 16'h2ABC);

        fe0 = ferr_seen;
        frame_begin();
        shift_bits(48'h17, 8);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cs = 1'b1;
        repeat (SYNC + 8) @(negedge clk);
        check("lit_rst_noerr", ferr_seen - fe0, 0);
        check("lit_rst_r1", reel1_idx, 0);
        check("lit_rst_total", total_credits, 0);
        send(48'h1777, 16, 0);
        check("lit_1777_r2", reel2_idx, 4'd7);

        send(48'h2000, 16, 1);
        check("lit_done_vs_spin", spin_busy, 1);
        pulse_done();

        for (int n = 0; n < 120; n++) begin
            bits = {16'($urandom), $urandom};
            r = $urandom_range(0, 9);
            opc = (r < 8) ? 4'(r % 5) : 4'($urandom_range(5, 15));
            bits[15:12] = opc;
            nbits = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : 16;
            send(bits, nbits, $urandom_range(0, 7) == 0);
            if (m_busy && $urandom_range(0, 2) == 0) pulse_done();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_game_link.md
# spi_game_link

Receives game-state commands from the host microcontroller over SPI and presents them as registered, clock-synchronous controls to the memory controller. It sits directly upstream of the memory controller, in the pixel-clock domain: sclk/copi/cs are oversampled, 16-bit frames are decoded into reel indices, spin start and credit values, and a status word is returned on sdo. The memory controller's `done` closes a spin.

## Interface
Parameters:
- SYNC_STAGES, 2, flops per input synchronizer (≥2)

Ports:
- clk  in  1  system/pixel clock; one clock domain; sclk must be ≤ clk/4
- reset  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock, async pad, mode 0 (CPOL=0, CPHA=0)
- copi  in  1  SPI data in, MSB first
- cs  in  1  SPI chip select, active low, async pad
- sdo  out  1  SPI status data out
- done  in  1  one-cycle pulse from memory controller: spin finished
- reel1_idx / reel2_idx / reel3_idx  out  4 each  final sprite index per reel
- start_spin  out  1  one-cycle pulse, begin spin
- win_credits  out  12  last reported win amount
- is_win  out  1  win_credits valid for the current result
- total_credits  out  12  credit balance
- is_total  out  1  total_credits has been written since reset
- spin_busy  out  1  spin in progress
- frame_err  out  1  one-cycle pulse, frame rejected

## Operation
- Each of sclk, copi, cs passes through a SYNC_STAGES synchronizer; sclk and cs get a registered edge detector.
- Frame = 16 bits, captured on synchronized sclk rising edges while cs low; opcode = bits[15:12], payload = bits[11:0].
- FSM: IDLE → SHIFT on cs fall (clear bit counter, load sdo shifter). SHIFT → COMMIT on cs rise. COMMIT → IDLE after one cycle.
- COMMIT with bit count ≠ 16 (short or long): discard, pulse frame_err.
- Opcodes at COMMIT:
  - 0x0: NOP.
  - 0x1: reels ← payload[11:8], [7:4], [3:0]. Rejected with frame_err if spin_busy.
  - 0x2: if not busy, pulse start_spin, set spin_busy, clear is_win. If busy, frame_err.
  - 0x3: win_credits ← payload, is_win ← 1.
  - 0x4: total_credits ← payload, is_total ← 1.
  - Any other opcode: frame_err.
- Rejected frames never modify any output except frame_err.
- spin_busy clears on `done`. `done` in the same cycle as a 0x2 commit: the commit wins, busy stays set.
- sdo: at cs fall, load {spin_busy, is_win, is_total, 1'b0, total_credits}. Drive the MSB, shift left on each synchronized sclk falling edge, shifting in 0. sdo = 0 in IDLE.
- Bit counter saturates at 31 and never wraps back to 16.

## Timing
- Reset: every output 0 (reels 0, credits 0, sdo 0, pulses low); FSM → IDLE. Reset mid-frame abandons the frame with no commit.
- Latency: outputs update, and pulses assert, SYNC_STAGES+2 clk cycles after the first clk edge that samples cs high.
- start_spin and frame_err are exactly one cycle wide.
- Back-to-back frames need ≥ SYNC_STAGES+3 clk cycles of cs high. A cs fall that arrives during COMMIT is taken in the following IDLE cycle.
- All outputs are registered; there is no combinational path from pads to outputs.

## Structure
- Package slot_spi_pkg holds:
  - opcode enum (OP_NOP, OP_REELS, OP_SPIN, OP_WIN, OP_TOTAL)
  - FSM state enum (IDLE, SHIFT, COMMIT)
  - FRAME_BITS = 16, CREDIT_W = 12, REEL_W = 4
- Sub-module sync_edge_detect (parameterized synchronizer, outputs level/rise/fall), instantiated for sclk, copi and cs. copi uses only the level output.

## Test plan
- Frame 0x1201, sclk = clk/8 → reel1=2, reel2=0, reel3=1 exactly SYNC_STAGES+2 cycles after cs rise; no frame_err.
- 0x2000 → single start_spin pulse, spin_busy=1. Then 0x1333 → frame_err, reels stay 2/0/1. After a `done` pulse, 0x1333 is accepted → 3/3/3.
- 0x3064 → win_credits=100, is_win=1. Next 0x2000 → is_win=0, win_credits still 100.
- Truncated frames of 9 bits and 17 bits → frame_err each, all outputs unchanged. Opcode 0xF → frame_err.
- 0x4ABC, then a 16-bit read with spin idle and no win → sdo stream 0x2ABC MSB first.
- Reset asserted after 8 bits of 0x1777 → all outputs 0, no commit. A following clean 0x1777 → reels 7/7/7.
